// File: rtl/seq_det_pkg.sv
// Shared state encoding and default sizing for the serial sequence detector.
package seq_det_pkg;

  localparam int unsigned MAX_LEN_DEF = 8;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned LEN_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/seq_pat_match.sv
// Bit history shift register, saturating fill counter and pattern compare.
module seq_pat_match
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift,
  input  logic               bit_in,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] mask_c;
  logic [MAX_LEN-1:0] window_c;

  // Window includes the bit arriving this cycle so hits are detected in the same cycle.
  always_comb begin
    window_c = {hist_q[MAX_LEN-2:0], bit_in};
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask_c[i] = (i < 32'(len));
    end
  end

  always_comb begin
    hit = shift && (len != '0) && (fill_q >= len - LEN_W'(1)) &&
          ((window_c & mask_c) == (pattern & mask_c));
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift) begin
      hist_d = window_c;
      if (fill_q < len) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Configurable serial pattern detector: config handshake, run control,
// overlapping match counting with optional target count.
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_target,
  output logic               cfg_err,
  input  logic               start,
  input  logic               abort,
  input  logic               in_valid,
  input  logic               in,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   tgt_q, tgt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               match_q, match_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;
  logic               busy_q, busy_d;
  logic               cfg_ready_q, cfg_ready_d;

  logic               hit_c;
  logic               clr_c;
  logic               shift_c;
  logic               cfg_len_ok_c;
  logic [CNT_W-1:0]   cnt_inc_c;

  assign clr_c        = (state_q == ARMED) && start && !abort;
  assign shift_c      = (state_q == RUN) && in_valid;
  assign cfg_len_ok_c = (cfg_len != '0) && (32'(cfg_len) <= MAX_LEN);
  assign cnt_inc_c    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  seq_pat_match #(
    .MAX_LEN (MAX_LEN)
  ) u_match (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_c),
    .shift   (shift_c),
    .bit_in  (in),
    .pattern (pat_q),
    .len     (len_q),
    .hit     (hit_c)
  );

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    match_d   = 1'b0;
    cfg_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          if (cfg_len_ok_c) begin
            pat_d   = cfg_pattern;
            len_d   = cfg_len;
            tgt_d   = cfg_target;
            state_d = ARMED;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ARMED: begin
        if (abort) begin
          state_d = DONE;
        end else if (start) begin
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // A hit in the abort cycle is still counted before leaving.
        if (hit_c) begin
          match_d = 1'b1;
          cnt_d   = cnt_inc_c;
          if ((tgt_q != '0) && (cnt_inc_c == tgt_q)) begin
            state_d = DONE;
          end
        end
        if (abort) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done_d      = (state_d == DONE);
    busy_d      = (state_d == RUN);
    cfg_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      tgt_q       <= '0;
      cnt_q       <= '0;
      match_q     <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      tgt_q       <= tgt_d;
      cnt_q       <= cnt_d;
      match_q     <= match_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      busy_q      <= busy_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = busy_q;
  assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: directed scenarios plus randomized runs
// against a queue-based reference model.
module tb_seq_detect_ctrl;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_RUN   = 2;
  localparam int M_DONE  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic [7:0] cfg_target;
  logic       cfg_err;
  logic       start;
  logic       abort;
  logic       in_valid;
  logic       in;
  logic       match;
  logic [7:0] match_cnt;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  seq_detect_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_target  (cfg_target),
    .cfg_err     (cfg_err),
    .start       (start),
    .abort       (abort),
    .in_valid    (in_valid),
    .in          (in),
    .match       (match),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    bit m;
    bit d;
    bit e;
    int cnt;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  match_seen = 0;
  int  done_seen = 0;
  int  err_seen = 0;

  // Reference model: run mode, received bits since start, hit count, latched config.
  int  mode = M_IDLE;
  bit  hist[$];
  int  m_cnt = 0;
  int  m_pat = 0;
  int  m_len = 0;
  int  m_tgt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one cycle of inputs, advances the model across the edge, then checks levels.
  task automatic step(input bit r, input bit cv, input logic [7:0] cp, input logic [3:0] cl,
                      input logic [7:0] ct, input bit st, input bit ab, input bit iv, input bit ib);
    ev_t ev;
    int  prev;
    bit  hit;
    int  v;
    rst = r; cfg_valid = cv; cfg_pattern = cp; cfg_len = cl; cfg_target = ct;
    start = st; abort = ab; in_valid = iv; in = ib;
    ev = '{m: 1'b0, d: 1'b0, e: 1'b0, cnt: 0};
    prev = mode;
    if (r) begin
      mode = M_IDLE; m_cnt = 0; m_pat = 0; m_len = 0; m_tgt = 0; hist.delete();
    end else begin
      case (mode)
        M_IDLE: begin
          if (cv) begin
            if (cl >= 1 && cl <= 8) begin
              m_pat = int'(cp); m_len = int'(cl); m_tgt = int'(ct); mode = M_ARMED;
            end else begin
              ev.e = 1'b1;
            end
          end
        end
        M_ARMED: begin
          if (ab) mode = M_DONE;
          else if (st) begin
            m_cnt = 0; hist.delete(); mode = M_RUN;
          end
        end
        M_RUN: begin
          if (iv) begin
            hist.push_back(ib);
            hit = 1'b0;
            if (hist.size() >= m_len) begin
              v = 0;
              for (int k = 0; k < m_len; k++) v = (v << 1) | int'(hist[hist.size() - m_len + k]);
              hit = (v == (m_pat & ((1 << m_len) - 1)));
            end
            if (hit) begin
              ev.m = 1'b1;
              if (m_cnt < 255) m_cnt++;
              if (m_tgt != 0 && m_cnt == m_tgt) mode = M_DONE;
            end
          end
          if (ab) mode = M_DONE;
        end
        default: mode = M_IDLE;
      endcase
      if (mode == M_DONE && prev != M_DONE) ev.d = 1'b1;
    end
    ev.cnt = m_cnt;
    if (ev.m || ev.d || ev.e) exp_q.push_back(ev);
    @(posedge clk);
    #1;
    chk("busy_level", int'(busy), int'(mode == M_RUN));
    chk("cfg_ready_level", int'(cfg_ready), int'(mode == M_IDLE));
    chk("match_cnt_level", int'(match_cnt), m_cnt);
  endtask

  task automatic idle();
    step(0, 0, 8'd0, 4'd0, 8'd0, 0, 0, 0, 0);
  endtask
  task automatic reset_c();
    step(1, 0, 8'd0, 4'd0, 8'd0, 0, 0, 0, 0);
  endtask
  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic [7:0] t);
    step(0, 1, p, l, t, 0, 0, 0, 0);
  endtask
  task automatic start_run();
    step(0, 0, 8'd0, 4'd0, 8'd0, 1, 0, 0, 0);
  endtask
  task automatic abort_c();
    step(0, 0, 8'd0, 4'd0, 8'd0, 0, 1, 0, 0);
  endtask
  task automatic bit_in(input bit b);
    step(0, 0, 8'd0, 4'd0, 8'd0, 0, 0, 1, b);
  endtask

  // Monitor: pops the next expected pulse whenever the DUT shows one.
  always @(negedge clk) begin
    ev_t ev;
    if (match === 1'b1 || done === 1'b1 || cfg_err === 1'b1) begin
      if (match === 1'b1) match_seen++;
      if (done === 1'b1) done_seen++;
      if (cfg_err === 1'b1) err_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse match=%0b done=%0b cfg_err=%0b cnt=%0d at %0t",
                 match, done, cfg_err, match_cnt, $time);
      end else begin
        ev = exp_q.pop_front();
        if (match !== ev.m || done !== ev.d || cfg_err !== ev.e || int'(match_cnt) != ev.cnt) begin
          errors++;
          $display("FAIL pulse_compare actual m=%0b d=%0b e=%0b cnt=%0d expected m=%0b d=%0b e=%0b cnt=%0d at %0t",
                   match, done, cfg_err, match_cnt, ev.m, ev.d, ev.e, ev.cnt, $time);
        end
      end
    end
  end

  initial begin
    bit b;
    int r;
    int base;
    bit s1[7] = '{1, 0, 1, 1, 0, 1, 1};
    bit s2[7] = '{1, 0, 1, 0, 1, 0, 1};
    bit s3[4] = '{1, 0, 1, 1};

    rst = 1'b1; cfg_valid = 0; cfg_pattern = 0; cfg_len = 0; cfg_target = 0;
    start = 0; abort = 0; in_valid = 0; in = 0;
    reset_c();
    reset_c();
    chk("rst_match", int'(match), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_match_cnt", int'(match_cnt), 0);
    idle();

    // Overlapping hits on 1011.
    base = match_seen;
    cfg(8'b1011, 4'd4, 8'd0);
    start_run();
    foreach (s1[i]) bit_in(s1[i]);
    idle();
    chk("overlap_hits", match_seen - base, 2);
    chk("overlap_cnt", int'(match_cnt), 2);
    abort_c();
    idle();

    // Target of 2 ends the run; remaining bits ignored.
    base = done_seen;
    cfg(8'b101, 4'd3, 8'd2);
    start_run();
    foreach (s2[i]) bit_in(s2[i]);
    idle();
    chk("target_done", done_seen - base, 1);
    chk("target_cnt", int'(match_cnt), 2);

    // Same stream as overlap with three idle cycles between bits.
    base = match_seen;
    cfg(8'b1011, 4'd4, 8'd0);
    start_run();
    foreach (s1[i]) begin
      bit_in(s1[i]);
      repeat (3) idle();
    end
    chk("gap_hits", match_seen - base, 2);
    chk("gap_cnt", int'(match_cnt), 2);
    abort_c();
    idle();

    // Illegal lengths.
    base = err_seen;
    cfg(8'hFF, 4'd0, 8'd0);
    cfg(8'hFF, 4'd9, 8'd0);
    idle();
    chk("bad_cfg_errs", err_seen - base, 2);
    chk("bad_cfg_idle", int'(cfg_ready), 1);

    // Abort after three bits.
    base = done_seen;
    cfg(8'b1011, 4'd4, 8'd0);
    start_run();
    for (int i = 0; i < 3; i++) bit_in(s1[i]);
    abort_c();
    idle();
    chk("abort_done", done_seen - base, 1);
    chk("abort_cnt", int'(match_cnt), 0);

    // Reset mid-run.
    base = done_seen;
    cfg(8'b1011, 4'd4, 8'd0);
    start_run();
    for (int i = 0; i < 3; i++) bit_in(s1[i]);
    reset_c();
    chk("rstrun_busy", int'(busy), 0);
    chk("rstrun_cfg_ready", int'(cfg_ready), 1);
    chk("rstrun_cnt", int'(match_cnt), 0);
    idle();
    idle();
    chk("rstrun_no_done", done_seen - base, 0);

    // Bits presented while armed must not count.
    base = match_seen;
    cfg(8'b1011, 4'd4, 8'd0);
    foreach (s3[i]) bit_in(s3[i]);
    start_run();
    bit_in(1'b0);
    idle();
    chk("prerun_no_match", match_seen - base, 0);
    abort_c();
    idle();

    // Randomized runs.
    repeat (60) begin
      cfg(8'($urandom), 4'($urandom_range(0, 9)), 8'($urandom_range(0, 3)));
      if (mode != M_ARMED) begin
        idle();
        continue;
      end
      repeat ($urandom_range(0, 3)) bit_in(1'($urandom_range(0, 1)));
      r = $urandom_range(0, 19);
      if (r == 0) step(0, 0, 8'd0, 4'd0, 8'd0, 1, 1, 0, 0);
      else if (r == 1) abort_c();
      else start_run();
      for (int c = 0; c < 40 && mode == M_RUN; c++) begin
        r = $urandom_range(0, 99);
        b = 1'($urandom_range(0, 1));
        if (r < 2) reset_c();
        else if (r < 6) step(0, 0, 8'd0, 4'd0, 8'd0, 0, 1, 1, b);
        else step(0, ($urandom_range(0, 7) == 0), 8'($urandom), 4'($urandom_range(1, 8)),
                  8'd1, 0, 0, ($urandom_range(0, 2) != 0), b);
      end
      if (mode == M_RUN) abort_c();
      repeat (3) if (mode != M_IDLE) idle();
    end

    repeat (3) idle();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
